// File: rtl/chan_seq_ctrl.sv
// chan_seq_ctrl: round-robin N-channel request sequencer with saturating per-channel service counters.
// Optional scan chain enabled by defining CHAN_SEQ_SCAN_EN.
`default_nettype none

module chan_seq_ctrl #(
  parameter int NCH  = 4,
  parameter int CW   = 4,
  parameter int HOLD = 3
) (
  input  logic              CK,
  input  logic              RN,
  input  logic [NCH-1:0]    G_REQ,
  input  logic [NCH-1:0]    G_MASK,
  input  logic              G_ACK,
  input  logic              G_CLR,
  output logic [NCH-1:0]    G_GNT,
  output logic [NCH-1:0]    G_GNTBF,
  output logic              G_BUSY,
  output logic [NCH*CW-1:0] G_CNT,
  output logic [NCH-1:0]    G_OVF
`ifdef CHAN_SEQ_SCAN_EN
  ,
  input  logic              G_SE,
  input  logic              G_SI,
  output logic              G_SO
`endif
);

  localparam int PW  = $clog2(NCH);
  localparam int HCW = 4;
  localparam logic [PW-1:0]  PTR_RST = PW'(NCH - 1);
  localparam logic [HCW-1:0] HC_INIT = (HOLD == 0) ? '0 : HCW'(HOLD - 1);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [HCW-1:0]      hc, hc_n;
  logic [NCH-1:0]      gnt, gnt_n;
  logic [NCH*CW-1:0]   cnt, cnt_n;
  logic [NCH-1:0]      ovf, ovf_n;

  logic [NCH-1:0]      elig;
  logic                found;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       gidx;

  assign elig = G_REQ & ~G_MASK;

  // Round-robin search starting at the channel after the last acknowledged one.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = 1; off <= NCH; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NCH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    gidx = ptr;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hc_n    = hc;
    gnt_n   = gnt;
    cnt_n   = cnt;
    ovf_n   = ovf;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (G_ACK) begin
          gnt_n   = '0;
          ptr_n   = gidx;
          hc_n    = HC_INIT;
          state_n = (HOLD == 0) ? S_IDLE : S_HOLD;
          for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
              if (cnt[i*CW +: CW] == CNT_MAX) ovf_n[i] = 1'b1;
              else cnt_n[i*CW +: CW] = cnt[i*CW +: CW] + CW'(1);
            end
          end
        end else if ((gnt & elig) == '0) begin
          gnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (hc == '0) state_n = S_IDLE;
        else          hc_n    = hc - HCW'(1);
      end
      default: begin
        gnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
    // Clear takes precedence over a same-cycle acknowledge.
    if (G_CLR) begin
      cnt_n = '0;
      ovf_n = '0;
    end
  end

`ifdef CHAN_SEQ_SCAN_EN
  localparam int SL = 2 + PW + HCW + NCH + NCH*CW + NCH;
  logic [SL-1:0] chain_q;
  logic [SL-1:0] chain_d;

  // Bit 0 is the head of the chain (first flop after G_SI).
  assign chain_q = {ovf, cnt, gnt, hc, ptr, state};
  assign chain_d = {chain_q[SL-2:0], G_SI};
  assign G_SO    = chain_q[SL-1];
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      ptr   <= PTR_RST;
      hc    <= '0;
      gnt   <= '0;
      cnt   <= '0;
      ovf   <= '0;
    end
`ifdef CHAN_SEQ_SCAN_EN
    else if (G_SE) begin
      state <= state_t'(chain_d[1:0]);
      ptr   <= chain_d[2 +: PW];
      hc    <= chain_d[2+PW +: HCW];
      gnt   <= chain_d[2+PW+HCW +: NCH];
      cnt   <= chain_d[2+PW+HCW+NCH +: NCH*CW];
      ovf   <= chain_d[2+PW+HCW+NCH+NCH*CW +: NCH];
    end
`endif
    else begin
      state <= state_n;
      ptr   <= ptr_n;
      hc    <= hc_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  assign G_GNT   = gnt;
  assign G_GNTBF = gnt;
  assign G_BUSY  = (state != S_IDLE);
  assign G_CNT   = cnt;
  assign G_OVF   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_chan_seq_ctrl.sv
// Self-checking bench for chan_seq_ctrl: scoreboard of expected grants plus a counter model.
`default_nettype none

module tb_chan_seq_ctrl;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int HOLD = 3;
  localparam int PW   = $clog2(NCH);
  localparam int MAXC = (1 << CW) - 1;

  logic              CK;
  logic              RN;
  logic [NCH-1:0]    G_REQ, G_MASK;
  logic              G_ACK, G_CLR;
  logic [NCH-1:0]    G_GNT, G_GNTBF, G_OVF;
  logic              G_BUSY;
  logic [NCH*CW-1:0] G_CNT;
`ifdef CHAN_SEQ_SCAN_EN
  localparam int SL = 2 + PW + 4 + NCH + NCH*CW + NCH;
  logic G_SE, G_SI, G_SO;
`endif

  chan_seq_ctrl #(.NCH(NCH), .CW(CW), .HOLD(HOLD)) dut (
    .CK(CK), .RN(RN), .G_REQ(G_REQ), .G_MASK(G_MASK), .G_ACK(G_ACK), .G_CLR(G_CLR),
    .G_GNT(G_GNT), .G_GNTBF(G_GNTBF), .G_BUSY(G_BUSY), .G_CNT(G_CNT), .G_OVF(G_OVF)
`ifdef CHAN_SEQ_SCAN_EN
    , .G_SE(G_SE), .G_SI(G_SI), .G_SO(G_SO)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NCH-1:0] exp_q[$];
  int             exp_cnt[NCH];
  logic [NCH-1:0] exp_ovf;

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [NCH*CW-1:0] pack_cnt();
    logic [NCH*CW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(exp_cnt[i]);
    return v;
  endfunction

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
    exp_ovf = '0;
    exp_q.delete();
  endtask

  task automatic model_ack(input int ch);
    if (exp_cnt[ch] == MAXC) exp_ovf[ch] = 1'b1;
    else exp_cnt[ch] = exp_cnt[ch] + 1;
  endtask

  task automatic do_reset();
    RN = 1'b0; G_REQ = '0; G_MASK = '0; G_ACK = 1'b0; G_CLR = 1'b0;
`ifdef CHAN_SEQ_SCAN_EN
    G_SE = 1'b0; G_SI = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge CK);
    #1 RN = 1'b1;
  endtask

  // Waits (bounded) for a grant and compares it with the scoreboard head.
  task automatic await_grant(input string tag, output int ch);
    int cyc;
    logic [NCH-1:0] exp;
    cyc = 0;
    ch  = 0;
    while (G_GNT == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: grant %b seen with empty scoreboard", tag, G_GNT);
    end else begin
      exp = exp_q.pop_front();
      ch  = onehot_idx(exp);
      if (G_GNT !== exp) begin
        n_fail++;
        $display("FAIL %s: grant %b expected %b (waited %0d cycles)", tag, G_GNT, exp, cyc);
      end
    end
  endtask

  task automatic test_reset();
    RN = 1'b0; G_REQ = '0; G_MASK = '0; G_ACK = 1'b0; G_CLR = 1'b0;
`ifdef CHAN_SEQ_SCAN_EN
    G_SE = 1'b0; G_SI = 1'b0;
`endif
    model_reset();
    #1;
    n_checks++; if (G_GNT !== '0)   begin n_fail++; $display("FAIL reset_gnt: %b expected 0", G_GNT); end
    n_checks++; if (G_GNTBF !== '0) begin n_fail++; $display("FAIL reset_gntbf: %b expected 0", G_GNTBF); end
    n_checks++; if (G_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b expected 0", G_BUSY); end
    n_checks++; if (G_CNT !== '0)   begin n_fail++; $display("FAIL reset_cnt: %h expected 0", G_CNT); end
    n_checks++; if (G_OVF !== '0)   begin n_fail++; $display("FAIL reset_ovf: %b expected 0", G_OVF); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [NCH-1:0] exp;
    G_REQ = 4'b0001;
    exp_q.push_back(4'b0001);
    step();
    exp = exp_q.pop_front();
    n_checks++; if (G_GNT !== exp)   begin n_fail++; $display("FAIL basic_gnt: %b expected %b", G_GNT, exp); end
    n_checks++; if (G_GNTBF !== exp) begin n_fail++; $display("FAIL basic_gntbf: %b expected %b", G_GNTBF, exp); end
    n_checks++; if (G_BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy: %b expected 1", G_BUSY); end
    G_ACK = 1'b1; G_REQ = '0;
    step();
    G_ACK = 1'b0;
    model_ack(0);
    n_checks++; if (G_CNT !== pack_cnt()) begin n_fail++; $display("FAIL basic_cnt: %h expected %h", G_CNT, pack_cnt()); end
    n_checks++; if (G_GNT !== '0) begin n_fail++; $display("FAIL basic_gnt_drop: %b expected 0", G_GNT); end
    for (int i = 0; i < HOLD; i++) begin
      n_checks++; if (G_BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_hold_busy[%0d]: %b expected 1", i, G_BUSY); end
      step();
    end
    n_checks++; if (G_BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_idle: %b expected 0", G_BUSY); end
  endtask

  task automatic test_round_robin();
    int cyc, ch;
    do_reset();
    G_REQ = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    step();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        cyc = 0;
        while (G_GNT == '0 && cyc < 20) begin step(); cyc++; end
        n_checks++;
        if (cyc != HOLD + 1) begin n_fail++; $display("FAIL rr_gap[%0d]: %0d cycles expected %0d", k, cyc, HOLD + 1); end
      end
      await_grant("rr_order", ch);
      G_ACK = 1'b1;
      step();
      G_ACK = 1'b0;
      model_ack(ch);
    end
    G_REQ = '0;
    repeat (HOLD + 1) step();
    n_checks++; if (G_CNT !== pack_cnt()) begin n_fail++; $display("FAIL rr_cnt: %h expected %h", G_CNT, pack_cnt()); end
  endtask

  task automatic test_mask_drop();
    int ch;
    do_reset();
    G_REQ = 4'b0010; G_MASK = 4'b0010;
    repeat (3) step();
    n_checks++; if (G_GNT !== '0 || G_BUSY !== 1'b0) begin n_fail++; $display("FAIL masked_req: gnt %b busy %b expected 0 0", G_GNT, G_BUSY); end
    G_MASK = '0; G_REQ = 4'b0100;
    exp_q.push_back(4'b0100);
    step();
    await_grant("drop_grant", ch);
    G_REQ = '0;
    step();
    n_checks++; if (G_GNT !== '0 || G_BUSY !== 1'b0) begin n_fail++; $display("FAIL drop_release: gnt %b busy %b expected 0 0", G_GNT, G_BUSY); end
    n_checks++; if (G_CNT !== pack_cnt()) begin n_fail++; $display("FAIL drop_cnt: %h expected %h", G_CNT, pack_cnt()); end
    // Pointer must still be 3, so ch2 wins over ch3.
    G_REQ = 4'b1100;
    exp_q.push_back(4'b0100);
    step();
    await_grant("drop_ptr_kept", ch);
    G_MASK = 4'b0100;
    step();
    n_checks++; if (G_GNT !== '0) begin n_fail++; $display("FAIL mask_in_wait: gnt %b expected 0", G_GNT); end
    G_MASK = '0; G_REQ = '0;
    step();
    G_ACK = 1'b1;
    repeat (2) step();
    G_ACK = 1'b0;
    n_checks++; if (G_CNT !== pack_cnt() || G_BUSY !== 1'b0) begin n_fail++; $display("FAIL ack_idle: cnt %h busy %b expected %h 0", G_CNT, G_BUSY, pack_cnt()); end
  endtask

  task automatic test_saturation();
    int ch;
    do_reset();
    G_REQ = 4'b0001;
    for (int k = 0; k < MAXC + 2; k++) begin
      exp_q.push_back(4'b0001);
      await_grant("sat_grant", ch);
      G_ACK = 1'b1;
      step();
      G_ACK = 1'b0;
      model_ack(ch);
      if (k == MAXC - 1) begin
        n_checks++;
        if (G_CNT !== pack_cnt() || G_OVF !== exp_ovf) begin n_fail++; $display("FAIL sat_edge: cnt %h ovf %b expected %h %b", G_CNT, G_OVF, pack_cnt(), exp_ovf); end
      end
    end
    n_checks++; if (G_CNT !== pack_cnt()) begin n_fail++; $display("FAIL sat_cnt: %h expected %h", G_CNT, pack_cnt()); end
    n_checks++; if (G_OVF !== exp_ovf)    begin n_fail++; $display("FAIL sat_ovf: %b expected %b", G_OVF, exp_ovf); end
    exp_q.push_back(4'b0001);
    await_grant("clr_grant", ch);
    G_ACK = 1'b1; G_CLR = 1'b1;
    step();
    G_ACK = 1'b0; G_CLR = 1'b0; G_REQ = '0;
    model_reset();
    n_checks++; if (G_CNT !== '0 || G_OVF !== '0) begin n_fail++; $display("FAIL clr_ack: cnt %h ovf %b expected 0 0", G_CNT, G_OVF); end
    n_checks++; if (G_BUSY !== 1'b1) begin n_fail++; $display("FAIL clr_fsm: busy %b expected 1", G_BUSY); end
    repeat (HOLD + 1) step();
  endtask

  task automatic test_async_reset();
    int ch;
    do_reset();
    G_REQ = 4'b0001;
    exp_q.push_back(4'b0001);
    await_grant("arst_grant", ch);
    G_ACK = 1'b1; G_REQ = '0;
    step();
    G_ACK = 1'b0;
    #2 RN = 1'b0;
    #1;
    n_checks++;
    if (G_GNT !== '0 || G_BUSY !== 1'b0 || G_CNT !== '0) begin n_fail++; $display("FAIL arst_async: gnt %b busy %b cnt %h expected 0 0 0", G_GNT, G_BUSY, G_CNT); end
    model_reset();
    @(posedge CK);
    #1 RN = 1'b1;
    G_REQ = 4'b1000;
    exp_q.push_back(4'b1000);
    step();
    n_checks++;
    if (G_GNT !== exp_q[0]) begin n_fail++; $display("FAIL arst_regrant: gnt %b expected %b", G_GNT, exp_q[0]); end
    void'(exp_q.pop_front());
    G_REQ = '0;
    step();
  endtask

`ifdef CHAN_SEQ_SCAN_EN
  task automatic test_scan();
    logic [SL-1:0] pat_a, pat_b;
    int ch;
    do_reset();
    for (int i = 0; i < SL; i++) pat_a[i] = 1'($urandom_range(0, 1));
    pat_b = {4'b1010, 16'h5A3C, 4'b0000, 4'd0, PW'(NCH - 1), 2'd0};
    G_SE = 1'b1;
    for (int i = SL - 1; i >= 0; i--) begin G_SI = pat_a[i]; step(); end
    for (int i = SL - 1; i >= 0; i--) begin
      n_checks++;
      if (G_SO !== pat_a[i]) begin n_fail++; $display("FAIL scan_so[%0d]: %b expected %b", i, G_SO, pat_a[i]); end
      G_SI = pat_b[i];
      step();
    end
    G_SE = 1'b0;
    n_checks++; if (G_CNT !== 16'h5A3C) begin n_fail++; $display("FAIL scan_cnt: %h expected 5a3c", G_CNT); end
    n_checks++; if (G_OVF !== 4'b1010 || G_BUSY !== 1'b0 || G_GNT !== '0) begin n_fail++; $display("FAIL scan_state: ovf %b busy %b gnt %b", G_OVF, G_BUSY, G_GNT); end
    G_REQ = 4'b1111;
    exp_q.push_back(4'b0001);
    step();
    await_grant("scan_resume", ch);
    G_REQ = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_mask_drop();
    test_saturation();
    test_async_reset();
`ifdef CHAN_SEQ_SCAN_EN
    test_scan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/chan_seq_ctrl.md
# chan_seq_ctrl

Parametrised N-channel request sequencer for the sequential benchmark set, successor to the fixed-width gate-level control benchmarks. It arbitrates round-robin among masked request lines, holds a one-hot grant until acknowledged, and keeps a saturating per-channel service counter with sticky overflow. Channel count, counter width and post-grant hold are configurable, and an optional full scan chain serves the test and locking flows.

## Interface
- NCH, 4, number of request channels (2..16)
- CW, 4, width of each per-channel service counter (2..8)
- HOLD, 3, idle cycles inserted after each acknowledged grant (0..15)

- CK  input  1  clock, all flops rising-edge
- RN  input  1  reset, asynchronous, active-low
- G_REQ  input  NCH  per-channel request, level
- G_MASK  input  NCH  per-channel mask; 1 = channel ineligible
- G_ACK  input  1  acknowledge of the current grant
- G_CLR  input  1  synchronous clear of counters and overflow flags
- G_GNT  output  NCH  registered one-hot grant
- G_GNTBF  output  NCH  buffered copy of G_GNT, identical value
- G_BUSY  output  1  1 when FSM is not IDLE, decoded from state register
- G_CNT  output  NCH*CW  per-channel counters, channel i at bits [i*CW +: CW]
- G_OVF  output  NCH  sticky overflow, one per channel

## Operation
- Reset (RN=0): FSM=IDLE, pointer PTR=NCH-1, hold counter=0, G_GNT=0, G_CNT=0, G_OVF=0, G_BUSY=0.
- Eligible vector E = G_REQ & ~G_MASK.
- IDLE: if E≠0, select first set bit of E searching PTR+1, PTR+2, … modulo NCH; load G_GNT with that one-hot; go WAIT. If E=0 stay IDLE.
- WAIT: G_GNT held. Priority per cycle: (1) G_ACK=1 → counter of granted channel increments, PTR ← granted index, G_GNT ← 0, go HOLD (or IDLE if HOLD=0), hold counter ← HOLD−1; (2) else granted channel's E bit is 0 (request dropped or masked) → G_GNT ← 0, PTR unchanged, go IDLE; (3) else stay.
- HOLD: G_GNT=0; hold counter decrements each cycle; at 0 go IDLE. Requests ignored.
- Counter increment saturates at 2^CW−1; an increment at saturation sets that channel's G_OVF and leaves count unchanged.
- G_CLR=1: all counters and G_OVF cleared next edge; FSM, PTR, G_GNT unaffected. CLR coinciding with ACK: clear wins, count ends 0, OVF 0.
- G_ACK outside WAIT is ignored.

## Timing
- Request-to-grant: E sampled at edge k in IDLE → G_GNT valid after edge k (one cycle from E assertion before edge).
- ACK at edge k → G_GNT low and counter updated after edge k; earliest next grant after edge k+HOLD+1.
- Back-to-back with HOLD=0: ACK at edge k, new grant after edge k+1.
- RN assertion mid-WAIT/HOLD drops G_GNT and G_BUSY immediately (asynchronous), all state to reset values; release synchronous to CK by integration.
- No combinational path from inputs to outputs.

## Configuration
- CHAN_SEQ_SCAN_EN defined: adds ports G_SE (input 1), G_SI (input 1), G_SO (output 1). G_SE=1 shifts every flop one position per CK, order: FSM state bits, PTR, hold counter, G_GNT[0..NCH−1], G_CNT ch0..chNCH−1 LSB first, G_OVF[0..NCH−1]; G_SO = last flop. Functional updates suppressed while G_SE=1; RN still overrides.
- Undefined: scan ports absent, behaviour as above.

## Test plan
- Reset then G_REQ=4'b0001, MASK=0 → G_GNT=0001 one cycle later, G_BUSY=1; ACK → CNT0=1, GNT=0, BUSY stays 1 for 3 cycles (HOLD=3) then 0.
- REQ=1111 held, ACK every grant → grant order 0,1,2,3,0 with HOLD gaps of 3 cycles.
- REQ=0010, MASK=0010 → no grant; in WAIT on ch2, drop REQ2 → GNT=0 next cycle, IDLE, CNT2 unchanged, next grant still searches from PTR+1.
- CW=2: 4 acks on ch0 → CNT0=3, OVF0=1; G_CLR with simultaneous ACK → CNT0=0, OVF0=0.
- RN pulled low during HOLD → GNT=0, BUSY=0, CNT=0 without a clock edge; after release REQ=1000 → ch3 granted.
- CHAN_SEQ_SCAN_EN: G_SE=1, shift known pattern through full chain length → identical pattern at G_SO; G_SE=0 resumes with shifted-in state.
